// File: rtl/sram_responder_if.sv
// sram_responder_if: request/response bus between a master and the SRAM responder
interface sram_responder_if;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_ready;
  logic        sram_rvalid;
  logic [31:0] sram_rdata;
  logic        sram_wack;
  logic        sram_err;
  modport master (
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_ready, sram_rvalid, sram_rdata, sram_wack, sram_err
  );
  modport slave (
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_ready, sram_rvalid, sram_rdata, sram_wack, sram_err
  );
endinterface

// File: rtl/sram_responder.sv
// sram_responder: single-outstanding word SRAM with byte-lane writes, wait states and range checking
module sram_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input logic             clk,
  input logic             reset,
  sram_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] idx_q;
  logic              oor_q;
  logic [3:0]        we_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mem [2**ADDR_W];
  logic              ready, rvalid, wack, err;
  logic [31:0]       rdata;
  logic              accept, go_resp, oor_in, oor_cur, is_read;
  logic [ADDR_W-1:0] idx_in, idx_cur;
  logic [3:0]        we_cur;
  logic [31:0]       rdata_cur;
  logic              unused;
  assign accept  = state == IDLE && bus.sram_en;
  assign idx_in  = bus.sram_addr[ADDR_W+1:2];
  assign oor_in  = (bus.sram_addr >> (ADDR_W + 2)) != 32'b0;
  assign unused  = ^bus.sram_addr[1:0];
  // With zero wait states RESP is entered straight from IDLE, so the response is built from the live request
  assign idx_cur = state == IDLE ? idx_in : idx_q;
  assign oor_cur = state == IDLE ? oor_in : oor_q;
  assign we_cur  = state == IDLE ? bus.sram_we : we_q;
  assign go_resp = (accept && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0);
  assign is_read = we_cur == 4'b0;
  assign rdata_cur = is_read && !oor_cur ? mem[idx_cur] : 32'b0;
  assign bus.sram_ready  = ready;
  assign bus.sram_rvalid = rvalid;
  assign bus.sram_wack   = wack;
  assign bus.sram_err    = err;
  assign bus.sram_rdata  = rdata;
  // Control FSM: accepts one request, counts wait states, then presents a one-cycle response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      ready  <= 1'b1;
      rvalid <= 1'b0;
      wack   <= 1'b0;
      err    <= 1'b0;
      rdata  <= 32'b0;
    end else begin
      unique case (state)
        IDLE:    if (bus.sram_en) state <= WAIT_CYCLES == 0 ? RESP : WAIT;
        WAIT:    if (cnt == 4'd0) state <= RESP;
        default: state <= IDLE;
      endcase
      cnt    <= accept ? WAIT_LOAD : (state == WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
      ready  <= state == RESP || (state == IDLE && !bus.sram_en);
      rvalid <= go_resp && is_read;
      wack   <= go_resp && !is_read;
      err    <= go_resp && oor_cur;
      rdata  <= go_resp ? rdata_cur : 32'b0;
    end
  end
  // Request capture: held stable for the whole access so later bus activity cannot disturb it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      oor_q   <= 1'b0;
      we_q    <= 4'b0;
      wdata_q <= 32'b0;
    end else if (accept) begin
      idx_q   <= idx_in;
      oor_q   <= oor_in;
      we_q    <= bus.sram_we;
      wdata_q <= bus.sram_wdata;
    end
  end
  // Array write at the edge ending RESP; wack is only high in RESP, and reset clears it so aborted writes never land
  always_ff @(posedge clk) begin
    if (wack && !err && !reset)
      for (int i = 0; i < 4; i++)
        if (we_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
  end
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: vector table, corner sequences and randomized model check of sram_responder
module tb_sram_responder;
  localparam int AW = 10;
  localparam int WC = 1;
  logic clk = 0;
  logic reset = 1;
  int checks = 0;
  int errors = 0;
  sram_responder_if bus();
  sram_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rv;
    logic        wk;
    logic        er;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl[$];
  logic [31:0] mdl [int];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic access(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                        output logic rv, output logic wk, output logic er, output logic [31:0] rd);
    int lat, busy_hi, rd_nz;
    @(negedge clk);
    chk("ready_before", 32'(bus.sram_ready), 1);
    bus.sram_en = 1; bus.sram_we = w; bus.sram_addr = a; bus.sram_wdata = d;
    @(posedge clk);
    #1;
    bus.sram_en = 0; bus.sram_we = 4'($urandom); bus.sram_addr = $urandom; bus.sram_wdata = $urandom;
    lat = 0; busy_hi = 0; rd_nz = 0; rv = 0; wk = 0; er = 0; rd = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      busy_hi += 32'(bus.sram_ready);
      if (bus.sram_rvalid || bus.sram_wack) begin
        lat = i; rv = bus.sram_rvalid; wk = bus.sram_wack; er = bus.sram_err; rd = bus.sram_rdata;
        break;
      end
      if (bus.sram_rdata != 0 || bus.sram_err) rd_nz++;
    end
    chk("latency", 32'(lat), 32'(WC + 1));
    chk("ready_low_while_busy", 32'(busy_hi), 0);
    chk("quiet_while_waiting", 32'(rd_nz), 0);
    @(negedge clk);
    chk("pulse_one_cycle", {bus.sram_rvalid, bus.sram_wack, bus.sram_err, bus.sram_ready}, 32'b0001);
    chk("rdata_zero_after", bus.sram_rdata, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    logic rv, wk, er;
    logic [31:0] rd;
    bus.sram_en = 1; bus.sram_we = 0; bus.sram_addr = 32'h10; bus.sram_wdata = 0;
    // reset held with a pending request: ready high, nothing accepted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_ready", 32'(bus.sram_ready), 1);
      chk("reset_outputs", {bus.sram_rvalid, bus.sram_wack, bus.sram_err}, 0);
      chk("reset_rdata", bus.sram_rdata, 0);
    end
    bus.sram_en = 0;
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_idle", {bus.sram_rvalid, bus.sram_wack, bus.sram_ready}, 32'b001);
    end
    tbl.push_back('{4'hF, 32'h10,       32'hDEADBEEF, 0, 1, 0, 0});
    tbl.push_back('{4'h0, 32'h10,       32'h0,        1, 0, 0, 32'hDEADBEEF});
    tbl.push_back('{4'h4, 32'h10,       32'h55555555, 0, 1, 0, 0});
    tbl.push_back('{4'h0, 32'h10,       32'h0,        1, 0, 0, 32'hDE55BEEF});
    tbl.push_back('{4'h3, 32'h12,       32'hABCDABCD, 0, 1, 0, 0});
    tbl.push_back('{4'h0, 32'h10,       32'h0,        1, 0, 0, 32'hDE55ABCD});
    tbl.push_back('{4'h0, 32'h13,       32'h0,        1, 0, 0, 32'hDE55ABCD});
    tbl.push_back('{4'hF, 32'h0,        32'h12345678, 0, 1, 0, 0});
    tbl.push_back('{4'h0, 32'h1000,     32'h0,        1, 0, 1, 0});
    tbl.push_back('{4'hF, 32'h1000,     32'hFFFFFFFF, 0, 1, 1, 0});
    tbl.push_back('{4'h0, 32'h0,        32'h0,        1, 0, 0, 32'h12345678});
    tbl.push_back('{4'hF, 32'hFFC,      32'hA5A5A5A5, 0, 1, 0, 0});
    tbl.push_back('{4'h8, 32'hFFD,      32'h11111111, 0, 1, 0, 0});
    tbl.push_back('{4'h0, 32'hFFF,      32'h0,        1, 0, 0, 32'h11A5A5A5});
    tbl.push_back('{4'h0, 32'h80000000, 32'h0,        1, 0, 1, 0});
    tbl.push_back('{4'h2, 32'hFFFFF004, 32'h77777777, 0, 1, 1, 0});
    tbl.push_back('{4'h0, 32'h4,        32'h0,        1, 0, 0, 32'h0});
    // word 1 is seeded first so the last table read has a known value
    access(4'hF, 32'h4, 32'h0, rv, wk, er, rd);
    foreach (tbl[i]) begin
      access(tbl[i].we, tbl[i].addr, tbl[i].wdata, rv, wk, er, rd);
      chk($sformatf("tbl%0d_rvalid", i), 32'(rv), 32'(tbl[i].rv));
      chk($sformatf("tbl%0d_wack", i), 32'(wk), 32'(tbl[i].wk));
      chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
    end
    // en held high for 6 cycles: only cycles 0 and 3 find the responder ready
    begin
      logic [5:0] mask;
      int pulses;
      mask = 0; pulses = 0;
      for (int k = 0; k < 9; k++) begin
        @(negedge clk);
        if (k == 0) begin bus.sram_en = 1; bus.sram_we = 0; bus.sram_addr = 32'h10; end
        if (k == 6) bus.sram_en = 0;
        if (k < 6) mask[k] = bus.sram_ready;
        pulses += 32'(bus.sram_rvalid);
      end
      chk("busy_accept_mask", 32'(mask), 32'b001001);
      chk("busy_rvalid_count", 32'(pulses), 2);
    end
    // reset during WAIT of a write: no wack, array untouched
    begin
      int pulses;
      @(negedge clk);
      bus.sram_en = 1; bus.sram_we = 4'hF; bus.sram_addr = 32'h10; bus.sram_wdata = 32'hCAFEF00D;
      @(posedge clk);
      #1 bus.sram_en = 0;
      @(negedge clk);
      chk("wait_ready_low", 32'(bus.sram_ready), 0);
      reset = 1;
      #1;
      chk("async_reset_ready", 32'(bus.sram_ready), 1);
      chk("async_reset_quiet", {bus.sram_rvalid, bus.sram_wack, bus.sram_err}, 0);
      @(negedge clk);
      reset = 0;
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        pulses += 32'(bus.sram_wack) + 32'(bus.sram_rvalid);
      end
      chk("aborted_write_no_pulse", 32'(pulses), 0);
      access(4'h0, 32'h10, 32'h0, rv, wk, er, rd);
      chk("aborted_write_old_word", rd, 32'hDE55ABCD);
    end
    // randomized traffic over 16 words checked against a byte-merging array model
    for (int w = 0; w < 16; w++) begin
      mdl[w] = $urandom;
      access(4'hF, 32'h100 + 32'(w) * 4, mdl[w], rv, wk, er, rd);
      chk("rand_init_wack", {31'b0, wk}, 1);
    end
    for (int n = 0; n < 300; n++) begin
      int w;
      logic [31:0] a, d, exp_rd;
      logic [3:0] we;
      logic oor;
      w = $urandom_range(0, 15);
      a = 32'h100 + 32'(w) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(12, 31));
      we = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      d = $urandom;
      oor = a >= 32'h1000;
      exp_rd = (we == 0 && !oor) ? mdl[w] : 32'h0;
      if (we != 0 && !oor)
        for (int b = 0; b < 4; b++)
          if (we[b]) mdl[w][8*b +: 8] = d[8*b +: 8];
      access(we, a, d, rv, wk, er, rd);
      chk("rand_kind", {30'b0, rv, wk}, we == 0 ? 32'b10 : 32'b01);
      chk("rand_err", 32'(er), 32'(oor));
      chk("rand_rdata", rd, exp_rd);
    end
    for (int w = 0; w < 16; w++) begin
      access(4'h0, 32'h100 + 32'(w) * 4, 32'h0, rv, wk, er, rd);
      chk("final_sweep", rd, mdl[w]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
